// File: rtl/sext_abs_pkg.sv
// Shared types and lane-slicing helpers for the sign/zero-extend, negate and abs pipeline.
// Purely declarative: no logic, no latency.
// No flow control lives here.
package sext_abs_pkg;

  // Per-beat operation; applies to every lane of the beat.
  typedef enum logic [1:0] {
    EXT_SEXT = 2'd0,
    EXT_ZEXT = 2'd1,
    EXT_NEG  = 2'd2,
    EXT_ABS  = 2'd3
  } ext_mode_e;

  localparam int MODE_W = 2;

  // LSB position of lane 'lane' in a bus packed with 'width'-bit fields.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sext_abs_lane.sv
// One lane: extends an IN_W field to OUT_W, then turns an extended value into the final result.
// Fully combinational; the two halves feed different pipeline stages in the parent.
// No flow control; the parent owns all handshaking.
module sext_abs_lane
  import sext_abs_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_fld,
  input  ext_mode_e        i_mode,
  output logic [OUT_W-1:0] o_ext,
  input  logic [OUT_W-1:0] i_ext,
  input  ext_mode_e        i_ext_mode,
  output logic [OUT_W-1:0] o_res,
  output logic             o_ovf
);

  // Most negative OUT_W value; only reachable as an extended value when widths match.
  localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};
  localparam bit               SAME_W  = (OUT_W == IN_W);

  logic signed [IN_W-1:0] w_fld_s;
  logic [OUT_W-1:0]       w_neg;
  logic                   w_is_min;

  assign w_fld_s  = i_fld;
  assign w_neg    = ~i_ext + OUT_W'(1);
  assign w_is_min = SAME_W && (i_ext == MIN_VAL);

  // Extension: only ZEXT zero-fills; NEG and ABS operate on the sign-extended value.
  always_comb begin
    o_ext = OUT_W'(w_fld_s);
    if (i_mode == EXT_ZEXT) begin
      o_ext = OUT_W'(i_fld);
    end
  end

  // Result: negate for NEG, negate-if-negative for ABS; the minimum value wraps onto itself.
  always_comb begin
    o_res = i_ext;
    o_ovf = 1'b0;
    case (i_ext_mode)
      EXT_NEG: begin
        o_res = w_neg;
        o_ovf = w_is_min;
      end
      EXT_ABS: begin
        if (i_ext[OUT_W-1]) begin
          o_res = w_neg;
        end
        o_ovf = w_is_min;
      end
      default: begin
        o_res = i_ext;
      end
    endcase
  end

endmodule

// File: rtl/sext_abs_pipe.sv
// Multi-lane extend/negate/abs unit with a saturating overflow-beat counter.
// Latency 2 cycles, 1 beat/cycle; two skid-free stages buffer at most 2 beats.
// in_ready follows out_ready combinationally; outputs hold while out_valid && !out_ready.
module sext_abs_pipe
  import sext_abs_pkg::*;
#(
  parameter int LANES = 5,
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MODE_W-1:0]      in_mode,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic [CNT_W-1:0]       ovf_count,
  input  logic                   ovf_clr
);

  if (IN_W < 2 || OUT_W < IN_W) begin : g_bad_params
    $error("sext_abs_pipe: requires IN_W >= 2 and OUT_W >= IN_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   r_s1_vld;
  ext_mode_e              r_s1_mode;
  logic [LANES*OUT_W-1:0] r_s1_ext;
  logic                   r_s2_vld;
  logic [LANES*OUT_W-1:0] r_s2_dat;
  logic [LANES-1:0]       r_s2_ovf;
  logic [CNT_W-1:0]       r_ovf_cnt;

  ext_mode_e              w_in_mode;
  logic [LANES*OUT_W-1:0] w_ext;
  logic [LANES*OUT_W-1:0] w_res;
  logic [LANES-1:0]       w_ovf;
  logic                   w_s2_open;
  logic                   w_in_fire;
  logic                   w_s1_move;
  logic                   w_out_fire;

  assign w_in_mode  = ext_mode_e'(in_mode);
  assign w_s2_open  = !r_s2_vld || out_ready;
  assign in_ready   = !r_s1_vld || w_s2_open;
  assign w_in_fire  = in_valid && in_ready;
  assign w_s1_move  = r_s1_vld && w_s2_open;
  assign w_out_fire = r_s2_vld && out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sext_abs_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .i_fld      (in_data[lane_lsb(k, IN_W) +: IN_W]),
      .i_mode     (w_in_mode),
      .o_ext      (w_ext[lane_lsb(k, OUT_W) +: OUT_W]),
      .i_ext      (r_s1_ext[lane_lsb(k, OUT_W) +: OUT_W]),
      .i_ext_mode (r_s1_mode),
      .o_res      (w_res[lane_lsb(k, OUT_W) +: OUT_W]),
      .o_ovf      (w_ovf[k])
    );
  end

  // Stage 1: capture extended lanes and the beat's mode on every accepted input beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_mode <= EXT_SEXT;
      r_s1_ext  <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_vld  <= 1'b1;
        r_s1_mode <= w_in_mode;
        r_s1_ext  <= w_ext;
      end else if (w_s1_move) begin
        r_s1_vld  <= 1'b0;
      end
    end
  end

  // Stage 2: final result and overflow flags; frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
      r_s2_ovf <= '0;
    end else begin
      if (w_s1_move) begin
        r_s2_vld <= 1'b1;
        r_s2_dat <= w_res;
        r_s2_ovf <= w_ovf;
      end else if (w_out_fire) begin
        r_s2_vld <= 1'b0;
      end
    end
  end

  // Count delivered beats carrying any overflow; clear has priority over a counted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_out_fire && (|r_s2_ovf) && (r_ovf_cnt != CNT_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_vld;
  assign out_data  = r_s2_dat;
  assign out_ovf   = r_s2_ovf;
  assign ovf_count = r_ovf_cnt;

endmodule

// File: tb/tb_sext_abs_pipe.sv
// Directed bench for sext_abs_pipe: a default instance (5 lanes, 4->8, 8-bit counter)
// and a same-width instance (2 lanes, 4->4, 2-bit counter) share clock, reset and control,
// followed by a short random stream on the default instance against a per-lane model.
module tb_sext_abs_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clr;
    logic [1:0]  in_mode;

    logic [19:0] a_in_data;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [39:0] a_out_data;
    logic [4:0]  a_out_ovf;
    logic [7:0]  a_ovf_count;

    logic [7:0]  b_in_data;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ovf;
    logic [1:0]  b_ovf_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] sbq[$];
    logic [39:0] exp_dat;
    bit          done     = 1'b0;

    sext_abs_pipe #(.LANES(5), .IN_W(4), .OUT_W(8), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_mode   (in_mode),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_ovf   (a_out_ovf),
        .ovf_count (a_ovf_count),
        .ovf_clr   (ovf_clr)
    );

    sext_abs_pipe #(.LANES(2), .IN_W(4), .OUT_W(4), .CNT_W(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_mode   (in_mode),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_ovf   (b_out_ovf),
        .ovf_count (b_ovf_count),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_a_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!a_out_valid && n < max_cycles) begin
            tick();
            n++;
        end
        n_checks++;
        if (!a_out_valid) begin
            n_fail++;
            $error("FAIL %s timeout after %0d cycles waiting for out_valid", tag, max_cycles);
        end
    endtask

    initial begin
        #1000000;
        if (!done) begin
            n_fail++;
            $error("FAIL watchdog expired before test completion");
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $finish;
        end
    end

    // Reference for the default instance, written with signed casts and unary minus.
    function automatic logic [39:0] model_a(input logic [1:0] m, input logic [19:0] d);
        logic [39:0]       r;
        logic [3:0]        u;
        logic signed [3:0] x;
        int                v;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            u = d[k*4 +: 4];
            x = signed'(u);
            case (m)
                2'd0:    v = int'(x);
                2'd1:    v = int'(u);
                2'd2:    v = -int'(x);
                default: v = (x < 0) ? -int'(x) : int'(x);
            endcase
            r[k*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [19:0] bp_in(input int k);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(15 - k);
        lo = 4'(k + 1);
        return {hi, 12'h000, lo};
    endfunction

    function automatic logic [39:0] bp_out(input int k);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(15 - k);
        lo = 4'(k + 1);
        return {4'hF, hi, 24'h000000, 4'h0, lo};
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        in_mode   = 2'd0;
        a_in_data = '0;
        b_in_data = '0;

        // Reset values
        #12;
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_data", a_out_data, 40'h0);
        chk("rst_a_ovf", a_out_ovf, 5'h0);
        chk("rst_b_count", b_ovf_count, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_a_in_ready", a_in_ready, 1'b1);

        // Four back-to-back beats, one per mode; lane0=-6, lane1=5 (A); lane0=-8, lane1=7 (B)
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        a_in_data = 20'h0005A;
        b_in_data = 8'h78;
        tick();
        chk("lat_a_not_yet", a_out_valid, 1'b0);
        in_mode = 2'd1;
        tick();
        chk("sext_a_valid", a_out_valid, 1'b1);
        chk("sext_a_data", a_out_data, 40'h00000005FA);
        chk("sext_a_ovf", a_out_ovf, 5'h0);
        chk("sext_b_data", b_out_data, 8'h78);
        chk("sext_b_ovf", b_out_ovf, 2'b00);
        in_mode = 2'd2;
        tick();
        chk("zext_a_data", a_out_data, 40'h000000050A);
        chk("zext_b_data", b_out_data, 8'h78);
        in_mode = 2'd3;
        tick();
        chk("neg_a_data", a_out_data, 40'h000000FB06);
        chk("neg_a_ovf", a_out_ovf, 5'h0);
        chk("neg_b_data", b_out_data, 8'h98);
        chk("neg_b_ovf", b_out_ovf, 2'b01);
        chk("neg_b_count", b_ovf_count, 2'd0);
        in_valid = 1'b0;
        tick();
        chk("abs_a_data", a_out_data, 40'h0000000506);
        chk("abs_b_data", b_out_data, 8'h78);
        chk("abs_b_ovf", b_out_ovf, 2'b01);
        chk("abs_b_count", b_ovf_count, 2'd1);
        tick();
        chk("drain_a_valid", a_out_valid, 1'b0);
        chk("drain_b_count", b_ovf_count, 2'd2);
        chk("drain_a_count", a_ovf_count, 8'd0);

        // Clear, then five overflowing beats saturate the 2-bit counter
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_b_count", b_ovf_count, 2'd0);
        in_mode  = 2'd2;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("sat_b_count_mid", b_ovf_count, 2'd2);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("sat_b_count", b_ovf_count, 2'd3);

        // Backpressure: consumer stalls for three cycles while four beats are offered
        in_mode   = 2'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in_data = bp_in(0);
        chk("bp_ready0", a_in_ready, 1'b1);
        tick();
        chk("bp_ready1", a_in_ready, 1'b1);
        a_in_data = bp_in(1);
        tick();
        chk("bp_valid", a_out_valid, 1'b1);
        chk("bp_hold0", a_out_data, bp_out(0));
        chk("bp_full0", a_in_ready, 1'b0);
        a_in_data = bp_in(2);
        tick();
        chk("bp_hold1", a_out_data, bp_out(0));
        chk("bp_full1", a_in_ready, 1'b0);
        tick();
        chk("bp_hold2", a_out_data, bp_out(0));
        chk("bp_hold2_valid", a_out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", a_in_ready, 1'b1);
        tick();
        chk("bp_out1", a_out_data, bp_out(1));
        a_in_data = bp_in(3);
        tick();
        chk("bp_out2", a_out_data, bp_out(2));
        in_valid = 1'b0;
        tick();
        chk("bp_out3", a_out_data, bp_out(3));
        chk("bp_out3_valid", a_out_valid, 1'b1);
        tick();
        chk("bp_empty", a_out_valid, 1'b0);
        chk("bp_b_count", b_ovf_count, 2'd3);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd2;
        a_in_data = 20'h12345;
        tick();
        tick();
        in_valid = 1'b0;
        chk("arst_pre_valid", a_out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_valid", a_out_valid, 1'b0);
        chk("arst_a_data", a_out_data, 40'h0);
        chk("arst_a_ovf", a_out_ovf, 5'h0);
        chk("arst_b_valid", b_out_valid, 1'b0);
        chk("arst_b_count", b_ovf_count, 2'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("arst_b_in_ready", b_in_ready, 1'b1);
        in_mode   = 2'd1;
        a_in_data = 20'h0000A;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arst_lat0", a_out_valid, 1'b0);
        tick();
        chk("arst_lat1", a_out_valid, 1'b1);
        chk("arst_lat_data", a_out_data, 40'h000000000A);
        tick();
        chk("arst_no_stale", a_out_valid, 1'b0);

        // Clear coinciding with an overflowing output beat wins
        in_mode  = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clrhit_b_ovf", b_out_ovf, 2'b01);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clrhit_b_count", b_ovf_count, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_a_valid("wait_after_clr_beat", 4);
        tick();
        chk("after_clr_b_count", b_ovf_count, 2'd1);

        // Random modes/data with random backpressure on the default instance
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            a_in_data = 20'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && a_in_ready) begin
                sbq.push_back(model_a(in_mode, a_in_data));
            end
            if (a_out_valid && out_ready) begin
                chk("rnd_expected_beat", (sbq.size() != 0), 1'b1);
                if (sbq.size() != 0) begin
                    exp_dat = sbq.pop_front();
                    chk("rnd_data", a_out_data, exp_dat);
                    chk("rnd_ovf", a_out_ovf, 5'h0);
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_out_valid) begin
                chk("rnd_drain_expected", (sbq.size() != 0), 1'b1);
                if (sbq.size() != 0) begin
                    exp_dat = sbq.pop_front();
                    chk("rnd_drain_data", a_out_data, exp_dat);
                end
            end
            tick();
        end
        chk("rnd_all_delivered", sbq.size(), 0);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sext_abs_pipe.md
Name: sext_abs_pipe

Overview:
- Multi-lane, parametrised width-conversion unit. Per lane: sign-extend, zero-extend, negate or absolute-value an IN_W-bit field into an OUT_W-bit result.
- Two-stage registered pipeline with valid/ready handshakes on both sides, per-lane overflow flags, and a saturating overflow event counter.
- Serves as the sequential, generalised successor of the cast/extension cosim specs; used as a DUT for signed-cast semantics under backpressure.

Parameters:
- LANES, 5, number of independent lanes packed in in_data/out_data.
- IN_W, 4, input field width per lane (>=2).
- OUT_W, 8, output field width per lane (>=IN_W; elaboration error otherwise).
- CNT_W, 8, width of ovf_count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat.
- in_mode  input  2  0=SEXT, 1=ZEXT, 2=NEG (negate of sign-extended), 3=ABS (of sign-extended).
- in_data  input  LANES*IN_W  lane k at bits [k*IN_W +: IN_W].
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts beat.
- out_data  output  LANES*OUT_W  lane k at bits [k*OUT_W +: OUT_W].
- out_ovf  output  LANES  per-lane overflow for the current output beat.
- ovf_count  output  CNT_W  saturating count of accepted output beats with any out_ovf bit set.
- ovf_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst_n low, async): all stage valids 0, out_valid=0, out_data=0, out_ovf=0, ovf_count=0. in_ready=1 once rst_n is high.
- Transfer rule: input beat when in_valid&&in_ready; output beat when out_valid&&out_ready.
- Stage 1 registers the extended value:
  - SEXT/NEG/ABS: replicate bit IN_W-1.
  - ZEXT: zero-fill.
  - Stage 1 also registers the mode.
- Stage 2 registers the final result:
  - NEG: two's complement of the stage-1 value, modulo 2^OUT_W.
  - ABS: negate iff the sign bit is set.
  - SEXT/ZEXT: pass-through.
- Overflow: set only for NEG/ABS when the input is -2^(IN_W-1) and OUT_W==IN_W. The result wraps to the same value (e.g. 4'h8) and out_ovf[k]=1. Overflow is impossible when OUT_W>IN_W. Negating 0 gives 0 with no overflow.
- Latency: 2 cycles from input beat to out_valid with no stall. Throughput: 1 beat/cycle.
- Pipeline advance: stage N may load when it is empty or its contents leave this cycle. in_ready = !s1_valid || s2 can load. in_ready may depend combinationally on out_ready; no combinational path from in_* to out_*.
- Stall: while out_valid && !out_ready, out_data, out_ovf and out_valid hold stable. At most 2 beats are buffered; in_ready drops when both stages are full.
- ovf_count:
  - increments by 1 on each output beat with |out_ovf; saturates at 2^CNT_W-1.
  - ovf_clr sets it to 0. If ovf_clr coincides with a counted beat, clear wins and the result is 0.
- Mid-operation reset drops all buffered beats; no partial beat is ever presented.
- Lanes are fully independent; mode is per beat and applies to all lanes.

Decomposition:
- Package sext_abs_pkg holds:
  - typedef enum logic [1:0] ext_mode_e {EXT_SEXT, EXT_ZEXT, EXT_NEG, EXT_ABS};
  - localparam helpers for lane slicing.
- Sub-module sext_abs_lane: parametrised IN_W/OUT_W combinational lane that returns the extended value, the result and ovf.
- The top level instantiates LANES copies via generate and owns the pipeline registers, handshake and counter.

Test Plan:
- Defaults, lane0=4'hA (-6), lane1=4'h5, out_ready=1:
  - SEXT -> 8'hFA/8'h05.
  - ZEXT -> 8'h0A/8'h05.
  - NEG -> 8'h06/8'hFB.
  - ABS -> 8'h06/8'h05.
  - out_valid exactly 2 cycles after each accepted beat, no ovf.
- OUT_W=IN_W=4, ABS of 4'h8 and NEG of 4'h8 -> out 4'h8, out_ovf[k]=1, ovf_count +1 per beat. ABS of 4'h7 -> 4'h7, ovf=0.
- Backpressure: stream 4 beats, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted beats, out_data held stable. Release -> beats emerge in order, none lost or duplicated.
- Counter: CNT_W=2, 5 overflowing beats -> ovf_count saturates at 3. ovf_clr asserted in the same cycle as an overflow beat -> 0.
- Reset asserted with 2 beats buffered -> out_valid=0, out_data=0, ovf_count=0 immediately (async). After release, the next beat has 2-cycle latency.
- Random mode/data with random out_ready over 10k beats -> scoreboard matches SV signed'()/unary-minus reference model per lane.
